// File: rtl/fmap_rowbuf_pkg.sv
// Shared types and defaults for the feature-map row buffer.
// Bank/writer state encodings and read-port command codes.
package mobilenet_pkg;

  localparam int DW_DEF   = 32;
  localparam int POY_DEF  = 3;
  localparam int BUFW_DEF = 48;

  localparam logic [1:0] RP_IDLE = 2'b00;
  localparam logic [1:0] RP_READ = 2'b01;
  localparam logic [1:0] RP_REL  = 2'b10;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } bank_st_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_WAIT
  } wr_st_e;

endpackage

// File: rtl/fmap_rowbuf_if.sv
// Pixel write handshake, read-port command and row outputs.
// Master drives pixels/commands; slave is the row buffer.
interface fmap_rowbuf_if
  import mobilenet_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int POY  = POY_DEF,
  parameter int BUFW = BUFW_DEF
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic [1:0]    rpsel;
  logic [7:0]    bank;
  logic [7:0]    row;
  logic [27:0]   col;
  logic [DW-1:0] data [POY][BUFW];
  logic          blkend;

  modport master (
    output wr_valid, wr_data, wr_last,
    output rpsel, bank, row, col,
    input  wr_ready, data, blkend
  );

  modport slave (
    input  wr_valid, wr_data, wr_last,
    input  rpsel, bank, row, col,
    output wr_ready, data, blkend
  );
endinterface

// File: rtl/fmap_rowbuf_bank.sv
// One POY x BUFW bank of pixel storage.
// Single write port plus a whole-bank synchronous clear.
module fmap_rowbuf_bank
  import mobilenet_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int POY  = POY_DEF,
  parameter int BUFW = BUFW_DEF,
  parameter int RW   = (POY > 1) ? $clog2(POY) : 1,
  parameter int CW   = $clog2(BUFW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          clr_i,
  input  logic [RW-1:0] wrow_i,
  input  logic [CW-1:0] wcol_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] mem_o [POY][BUFW]
);

  logic [DW-1:0] mem_q [POY][BUFW];

  // Storage: clear wins over write; never both in practice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POY; i++)
        for (int j = 0; j < BUFW; j++)
          mem_q[i][j] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < POY; i++)
        for (int j = 0; j < BUFW; j++)
          mem_q[i][j] <= '0;
    end else if (we_i) begin
      mem_q[wrow_i][wcol_i] <= wdata_i;
    end
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/fmap_rowbuf.sv
// Double-banked feature-map row buffer with rotated reads.
// Writer fills one bank while the other is read out.
module fmap_rowbuf
  import mobilenet_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int POY  = POY_DEF,
  parameter int BUFW = BUFW_DEF
) (
  input logic       clk,
  input logic       rst_n,
  fmap_rowbuf_if.slave bus
);

  localparam int RW = (POY > 1) ? $clog2(POY) : 1;
  localparam int CW = $clog2(BUFW);

  bank_st_e      bst_q [2];
  bank_st_e      bst_d [2];
  wr_st_e        wst_q, wst_d;
  logic          wbank_q, wbank_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic          blkend_q, blkend_d;
  logic          en_q;

  logic [DW-1:0] m0 [POY][BUFW];
  logic [DW-1:0] m1 [POY][BUFW];
  logic [DW-1:0] src [POY][BUFW];
  logic [DW-1:0] rd_d [POY][BUFW];
  logic [DW-1:0] data_q [POY][BUFW];

  logic          bsel, hs, cmpl, rel, rd, nxt_busy;
  logic [RW-1:0] rot;
  logic [CW-1:0] coff;
  logic          unused_bits;

  assign bsel = bus.bank[0];
  assign rot  = RW'(bus.row % POY);
  assign coff = bus.col[CW-1:0];
  assign unused_bits = ^{bus.bank[7:1], bus.col[27:CW]};

  assign bus.wr_ready = en_q && (bst_q[wbank_q] != FULL);
  assign hs   = bus.wr_valid && bus.wr_ready;
  assign cmpl = hs && (bus.wr_last ||
    (wrow_q == RW'(POY-1) && wcol_q == CW'(BUFW-1)));
  assign rel  = (bus.rpsel == RP_REL) && (bst_q[bsel] == FULL);
  assign rd   = (bus.rpsel == RP_READ) && (bst_q[bsel] == FULL);
  assign nxt_busy = (bst_q[~wbank_q] == FULL) &&
    !(rel && bsel == ~wbank_q);

  fmap_rowbuf_bank #(.DW(DW), .POY(POY), .BUFW(BUFW)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (hs && !wbank_q),
    .clr_i   (rel && !bsel),
    .wrow_i  (wrow_q),
    .wcol_i  (wcol_q),
    .wdata_i (bus.wr_data),
    .mem_o   (m0)
  );

  fmap_rowbuf_bank #(.DW(DW), .POY(POY), .BUFW(BUFW)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (hs && wbank_q),
    .clr_i   (rel && bsel),
    .wrow_i  (wrow_q),
    .wcol_i  (wcol_q),
    .wdata_i (bus.wr_data),
    .mem_o   (m1)
  );

  // Writer next state: pointer advance, bank states, FSM.
  always_comb begin
    bst_d    = bst_q;
    wst_d    = wst_q;
    wbank_d  = wbank_q;
    wrow_d   = wrow_q;
    wcol_d   = wcol_q;
    blkend_d = cmpl;
    if (rel)
      bst_d[bsel] = EMPTY;
    if (hs) begin
      bst_d[wbank_q] = FILL;
      if (cmpl) begin
        bst_d[wbank_q] = FULL;
        wrow_d  = '0;
        wcol_d  = '0;
        wbank_d = ~wbank_q;
      end else if (wcol_q == CW'(BUFW-1)) begin
        wcol_d = '0;
        wrow_d = wrow_q + 1'b1;
      end else begin
        wcol_d = wcol_q + 1'b1;
      end
    end
    unique case (wst_q)
      W_IDLE:
        if (cmpl)    wst_d = nxt_busy ? W_WAIT : W_IDLE;
        else if (hs) wst_d = W_FILL;
      W_FILL:
        if (cmpl) wst_d = nxt_busy ? W_WAIT : W_IDLE;
      W_WAIT:
        if (rel && bsel == wbank_q) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Writer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q[0] <= EMPTY;
      bst_q[1] <= EMPTY;
      wst_q    <= W_IDLE;
      wbank_q  <= 1'b0;
      wrow_q   <= '0;
      wcol_q   <= '0;
      blkend_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      bst_q    <= bst_d;
      wst_q    <= wst_d;
      wbank_q  <= wbank_d;
      wrow_q   <= wrow_d;
      wcol_q   <= wcol_d;
      blkend_q <= blkend_d;
      en_q     <= 1'b1;
    end
  end

  // Rotated, column-shifted view of the selected bank.
  always_comb begin
    if (bsel) src = m1;
    else      src = m0;
    for (int i = 0; i < POY; i++)
      for (int j = 0; j < BUFW; j++)
        rd_d[i][j] = (j + int'(coff) < BUFW) ?
          src[RW'((i + int'(rot)) % POY)][CW'(j + int'(coff))] :
          '0;
  end

  // Output rows update only on a read of a FULL bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POY; i++)
        for (int j = 0; j < BUFW; j++)
          data_q[i][j] <= '0;
    end else if (rd) begin
      data_q <= rd_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.blkend = blkend_q;

endmodule

// File: tb/tb_fmap_rowbuf.sv
// Directed bench for fmap_rowbuf.
// Hand-computed expected pixels after fill/read/release flows.
module tb_fmap_rowbuf;
  import mobilenet_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   cnt;

  fmap_rowbuf_if #(.DW(32), .POY(3), .BUFW(48)) bus ();

  fmap_rowbuf #(.DW(32), .POY(3), .BUFW(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic last);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    bus.wr_last  = last;
    while (!bus.wr_ready && n < 400) begin
      tick();
      n++;
    end
    if (!bus.wr_ready) chk("push_timeout", 64'd0, 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic rd(input logic b, input int r, input int c);
    bus.rpsel = RP_READ;
    bus.bank  = {7'd0, b};
    bus.row   = 8'(r);
    bus.col   = 28'(c);
    tick();
    bus.rpsel = RP_IDLE;
  endtask

  task automatic rel(input logic b);
    bus.rpsel = RP_REL;
    bus.bank  = {7'd0, b};
    tick();
    bus.rpsel = RP_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rpsel    = RP_IDLE;
    bus.bank     = '0;
    bus.row      = '0;
    bus.col      = '0;
    tick();
    tick();
    chk("rst_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_blkend", 64'(bus.blkend), 64'd0);
    chk("rst_d00", 64'(bus.data[0][0]), 64'd0);
    chk("rst_d247", 64'(bus.data[2][47]), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_up", 64'(bus.wr_ready), 64'd1);

    cnt = 0;
    for (int k = 1; k <= 143; k++) begin
      push(32'(k), 1'b0);
      cnt += int'(bus.blkend);
    end
    chk("no_early_blkend", 64'(cnt), 64'd0);
    push(32'd144, 1'b0);
    chk("blkend_144", 64'(bus.blkend), 64'd1);
    tick();
    chk("blkend_drop", 64'(bus.blkend), 64'd0);
    chk("wbank_1", 64'(dut.wbank_q), 64'd1);
    chk("bank0_full", 64'(dut.bst_q[0]), 64'(FULL));

    rd(1'b0, 0, 0);
    chk("r0_d00", 64'(bus.data[0][0]), 64'd1);
    chk("r0_d047", 64'(bus.data[0][47]), 64'd48);
    chk("r0_d10", 64'(bus.data[1][0]), 64'd49);
    chk("r0_d247", 64'(bus.data[2][47]), 64'd144);
    rd(1'b0, 1, 2);
    chk("r1_d00", 64'(bus.data[0][0]), 64'd51);
    chk("r1_d20", 64'(bus.data[2][0]), 64'd3);
    chk("r1_d246", 64'(bus.data[2][46]), 64'd0);
    chk("r1_d145", 64'(bus.data[1][45]), 64'd144);
    rd(1'b1, 0, 0);
    chk("rd_empty_hold", 64'(bus.data[0][0]), 64'd51);
    bus.rpsel = 2'b11;
    tick();
    bus.rpsel = RP_IDLE;
    chk("rp11_hold", 64'(bus.data[0][0]), 64'd51);

    for (int k = 1; k <= 144; k++) push(32'(1000 + k), 1'b0);
    chk("blkend_b1", 64'(bus.blkend), 64'd1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'd1;
    tick();
    tick();
    tick();
    chk("wait_ready", 64'(bus.wr_ready), 64'd0);
    chk("wait_state", 64'(dut.wst_q), 64'(W_WAIT));
    bus.rpsel = RP_REL;
    bus.bank  = 8'd0;
    tick();
    bus.rpsel = RP_READ;
    bus.row   = 8'd0;
    bus.col   = 28'd0;
    chk("rel_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.rpsel    = RP_IDLE;
    bus.wr_valid = 1'b0;
    chk("rel_rd_hold", 64'(bus.data[0][0]), 64'd51);
    chk("rel_rd_hold2", 64'(bus.data[1][45]), 64'd144);

    for (int k = 2; k <= 9; k++) push(32'(k), 1'b0);
    push(32'd10, 1'b1);
    chk("blkend_last", 64'(bus.blkend), 64'd1);
    rd(1'b0, 0, 0);
    chk("l_d00", 64'(bus.data[0][0]), 64'd1);
    chk("l_d09", 64'(bus.data[0][9]), 64'd10);
    chk("l_d010", 64'(bus.data[0][10]), 64'd0);
    chk("l_d10", 64'(bus.data[1][0]), 64'd0);
    rd(1'b1, 2, 5);
    chk("b1_d00", 64'(bus.data[0][0]), 64'd1102);
    chk("b1_d10", 64'(bus.data[1][0]), 64'd1006);

    rel(1'b1);
    for (int k = 1; k <= 144; k++) push(32'(2000 + k), 1'b0);
    chk("wait2_ready", 64'(bus.wr_ready), 64'd0);
    rel(1'b0);
    for (int k = 1; k <= 143; k++) push(32'(3000 + k), 1'b0);
    bus.rpsel = RP_REL;
    bus.bank  = 8'd1;
    push(32'd3144, 1'b0);
    bus.rpsel = RP_IDLE;
    chk("same_blkend", 64'(bus.blkend), 64'd1);
    chk("same_ready", 64'(bus.wr_ready), 64'd1);
    chk("same_b1_empty", 64'(dut.bst_q[1]), 64'(EMPTY));
    rd(1'b0, 0, 0);
    chk("s_d00", 64'(bus.data[0][0]), 64'd3001);
    chk("s_d247", 64'(bus.data[2][47]), 64'd3144);
    rd(1'b1, 0, 0);
    chk("s_b1_hold", 64'(bus.data[0][0]), 64'd3001);

    for (int k = 1; k <= 20; k++) push(32'(4000 + k), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.wr_ready), 64'd0);
    chk("mid_rst_blkend", 64'(bus.blkend), 64'd0);
    chk("mid_rst_d00", 64'(bus.data[0][0]), 64'd0);
    chk("mid_rst_d247", 64'(bus.data[2][47]), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt += int'(bus.blkend);
    end
    chk("no_blkend_rst", 64'(cnt), 64'd0);
    chk("post_rst_ready", 64'(bus.wr_ready), 64'd1);
    push(32'd55, 1'b1);
    chk("post_blkend", 64'(bus.blkend), 64'd1);
    rd(1'b0, 0, 0);
    chk("post_d00", 64'(bus.data[0][0]), 64'd55);
    chk("post_d01", 64'(bus.data[0][1]), 64'd0);
    rd(1'b1, 0, 0);
    chk("post_b1_hold", 64'(bus.data[0][0]), 64'd55);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fmap_rowbuf.md
FMAP_ROWBUF -- requirements
Module: fmap_rowbuf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 32, pixel word width.
- POY, 3, rows per bank, equal to output lanes.
- BUFW, 48, words per row.
- The column-offset width is ceil(log2(BUFW)), which is 6 at the default.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- wr_valid, in, 1: write pixel valid.
- wr_ready, out, 1: write pixel accepted when high together with wr_valid.
- wr_data, in, DW: pixel, raster order within the block.
- wr_last, in, 1: final pixel of a block.
- rpsel, in, 2: read-port command; 00 idle, 01 read, 10 release, 11 ignored.
- bank, in, 8: bit 0 selects bank 0 or 1; bits 7:1 ignored.
- row, in, 8: row rotation offset, taken modulo POY.
- col, in, 28: column offset; the low 6 bits are used and must be below BUFW.
- data, out, DW x POY x BUFW: unpacked output rows.
- blkend, out, 1: one-cycle pulse when a bank becomes FULL.

Function
REQ-003 Storage: two banks, each POY x BUFW words; each bank has a state of EMPTY, FILL or FULL.
REQ-004 Write pointer wbank: wr_ready is high only while bank[wbank] is EMPTY or FILL.
REQ-005 On each write handshake, the word is stored at (wrow, wcol) of wbank and the bank state becomes FILL.
- wcol increments and wraps at BUFW-1.
- On that wrap, wrow increments.
REQ-006 Block completion occurs on the handshake at (POY-1, BUFW-1) or on a handshake with wr_last=1, whichever comes first.
- The bank becomes FULL.
- wrow and wcol clear.
- wbank toggles.
- blkend pulses in the next cycle.
- Words not written in that bank stay zero.
REQ-007 Writer FSM states and transitions:
- W_IDLE to W_FILL on the first handshake.
- W_FILL to W_IDLE on completion when the next bank is EMPTY.
- W_FILL to W_WAIT on completion when the next bank is FULL; wr_ready is low in W_WAIT.
- W_WAIT to W_IDLE when that bank is released.
REQ-008 Read command (rpsel=01) to a FULL bank b: one cycle later, data[i][j] equals bank b word at row (i+row) mod POY, column j+col.
- Columns j+col >= BUFW return zero.
REQ-009 Read of a bank that is not FULL, or rpsel 00 or 11: data holds its previous value.
REQ-010 Release command (rpsel=10) to a FULL bank: the bank becomes EMPTY and all its words clear to zero at the next edge.
- Release of a bank that is not FULL is ignored.
REQ-011 Release and completion in the same cycle on different banks both take effect.
- wr_ready rises in the following cycle when the released bank is next in line.
REQ-012 A read and a release of the same bank cannot occur together, because rpsel carries one command per cycle.
- A release followed immediately by a read of the same bank obeys REQ-009.
REQ-013 Writes never target a FULL bank, so read data is never torn.

Reset
REQ-014 While rst_n is low:
- Both banks are EMPTY and all words are zero.
- wbank, wrow and wcol are 0.
- The FSM is in W_IDLE.
- data is all zero.
- blkend is 0.
- wr_ready is 0.
REQ-015 wr_ready rises on the first clock edge after reset deassertion.
REQ-016 Reset asserted mid-block discards the partial block.
- No blkend is issued.

Structure
REQ-017 The shared package mobilenet_pkg holds:
- default DW, POY and BUFW;
- the rpsel command constants RP_IDLE, RP_READ and RP_REL;
- the bank-state enum {EMPTY, FILL, FULL};
- the writer-FSM enum.
REQ-018 One sub-module fmap_rowbuf_bank is instantiated twice.
- It contains one bank's POY x BUFW storage, a write port and a synchronous clear.
- Rotation, offset and output registers live in the top level.

Verification
REQ-019 Reset, then write 144 words with values 1..144 and no wr_last:
- blkend pulses once, one cycle after the 144th handshake.
- Bank 0 is FULL.
- wbank is 1.
REQ-020 Read bank 0 with row=0 and col=0:
- One cycle later, data[0][0]=1, data[0][47]=48, data[2][47]=144.
- Repeat with row=1 and col=2: data[0][0]=51, data[2][0]=3, data[2][46]=0.
REQ-021 Fill both banks, then hold wr_valid high:
- wr_ready stays low (W_WAIT).
- Release bank 0: wr_ready is high in the following cycle, and a read of bank 0 keeps data unchanged.
REQ-022 Write 10 words with wr_last on the 10th:
- blkend pulses.
- A read returns data[0][9]=10, data[0][10]=0 and data[1][0]=0.
REQ-023 Release bank 1 while the 144th word of bank 0 completes in the same cycle:
- Both take effect.
- blkend pulses.
- Then assert rst_n low after 20 words of a new block: all outputs are zero, and no blkend follows after release.
